// File: rtl/vector_load_sequencer_if.sv
// Control and handshake bundle between the test-vector loader sequencer and its consumer.
// Widths are derived here exactly as in the sequencer so both sides agree.
interface vector_load_sequencer_if #(
  parameter int unsigned PARALLELISM = 1,
  parameter int unsigned WORD_LEN    = 1023,
  parameter int unsigned WORD_NUM    = 10
);
  localparam int unsigned P_EFF      = (PARALLELISM == 0) ? 1 : PARALLELISM;
  localparam int unsigned WN_EFF     = (WORD_NUM == 0) ? 1 : WORD_NUM;
  localparam int unsigned CHUNKS_RAW = (WORD_LEN + P_EFF - 1) / P_EFF;
  localparam int unsigned CHUNKS     = (CHUNKS_RAW == 0) ? 1 : CHUNKS_RAW;
  localparam int unsigned WW         = ($clog2(WN_EFF) < 1) ? 1 : $clog2(WN_EFF);
  localparam int unsigned CW         = ($clog2(CHUNKS) < 1) ? 1 : $clog2(CHUNKS);
  localparam int unsigned LW         = $clog2(P_EFF + 1);

  logic          in_start;
  logic          in_abort;
  logic          in_ready;
  logic          out_ldr_Srst;
  logic          out_ldr_en;
  logic          out_ldr_next_word;
  logic          out_valid;
  logic          out_first_chunk;
  logic          out_last_chunk;
  logic          out_last_word;
  logic [WW-1:0] out_word_idx;
  logic [CW-1:0] out_chunk_idx;
  logic [LW-1:0] out_lanes;
  logic          out_busy;
  logic          out_done;

  modport master (
    output in_start, in_abort, in_ready,
    input  out_ldr_Srst, out_ldr_en, out_ldr_next_word, out_valid,
    input  out_first_chunk, out_last_chunk, out_last_word,
    input  out_word_idx, out_chunk_idx, out_lanes, out_busy, out_done
  );

  modport slave (
    input  in_start, in_abort, in_ready,
    output out_ldr_Srst, out_ldr_en, out_ldr_next_word, out_valid,
    output out_first_chunk, out_last_chunk, out_last_word,
    output out_word_idx, out_chunk_idx, out_lanes, out_busy, out_done
  );
endinterface

// File: rtl/vector_load_sequencer.sv
// Walks a binary test-vector file word by word in P-bit chunks, driving the loader
// controls and exporting per-chunk position/lane information to downstream.
module vector_load_sequencer #(
  parameter int unsigned PARALLELISM = 1,
  parameter int unsigned WORD_LEN    = 1023,
  parameter int unsigned WORD_NUM    = 10
) (
  input  logic                   clk,
  input  logic                   in_Arst_n,
  vector_load_sequencer_if.slave bus
);
  localparam int unsigned P_EFF      = (PARALLELISM == 0) ? 1 : PARALLELISM;
  localparam int unsigned WN_EFF     = (WORD_NUM == 0) ? 1 : WORD_NUM;
  localparam int unsigned CHUNKS_RAW = (WORD_LEN + P_EFF - 1) / P_EFF;
  localparam int unsigned CHUNKS     = (CHUNKS_RAW == 0) ? 1 : CHUNKS_RAW;
  localparam int unsigned REM        = WORD_LEN % P_EFF;
  localparam int unsigned LAST_LANES = (REM == 0) ? P_EFF : REM;
  localparam int unsigned WW         = ($clog2(WN_EFF) < 1) ? 1 : $clog2(WN_EFF);
  localparam int unsigned CW         = ($clog2(CHUNKS) < 1) ? 1 : $clog2(CHUNKS);
  localparam int unsigned LW         = $clog2(P_EFF + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADV    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q,     state_d;
  logic [WW-1:0] word_idx_q,  word_idx_d;
  logic [CW-1:0] chunk_idx_q, chunk_idx_d;

  logic last_chunk;
  logic last_word;

  assign last_chunk = (chunk_idx_q == CW'(CHUNKS - 1));
  assign last_word  = (word_idx_q  == WW'(WN_EFF - 1));

  // State and position counters
  always_ff @(posedge clk or negedge in_Arst_n) begin
    if (!in_Arst_n) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      chunk_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      chunk_idx_q <= chunk_idx_d;
    end
  end

  // Next-state: a stalled STREAM cycle leaves everything untouched; abort overrides all.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    chunk_idx_d = chunk_idx_q;
    case (state_q)
      ST_IDLE: begin
        word_idx_d  = '0;
        chunk_idx_d = '0;
        if (bus.in_start) state_d = ST_ADV;
      end
      ST_ADV: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (bus.in_ready) begin
          if (!last_chunk) begin
            chunk_idx_d = chunk_idx_q + CW'(1);
          end else if (!last_word) begin
            word_idx_d  = word_idx_q + WW'(1);
            chunk_idx_d = '0;
            state_d     = ST_ADV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        word_idx_d  = '0;
        chunk_idx_d = '0;
        state_d     = ST_IDLE;
      end
      default: begin
        word_idx_d  = '0;
        chunk_idx_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
    if (bus.in_abort) begin
      state_d     = ST_IDLE;
      word_idx_d  = '0;
      chunk_idx_d = '0;
    end
  end

  // Loader controls: enable follows ready while streaming since loader data is combinational.
  assign bus.out_ldr_Srst      = (state_q == ST_IDLE);
  assign bus.out_ldr_en        = !bus.in_abort &&
                                 ((state_q == ST_ADV) || ((state_q == ST_STREAM) && bus.in_ready));
  assign bus.out_ldr_next_word = !bus.in_abort && (state_q == ST_ADV);
  assign bus.out_valid         = !bus.in_abort && (state_q == ST_STREAM);
  assign bus.out_busy          = (state_q != ST_IDLE);
  assign bus.out_done          = (state_q == ST_DONE);

  assign bus.out_first_chunk = (chunk_idx_q == '0);
  assign bus.out_last_chunk  = last_chunk;
  assign bus.out_last_word   = last_word;
  assign bus.out_word_idx    = word_idx_q;
  assign bus.out_chunk_idx   = chunk_idx_q;
  assign bus.out_lanes       = last_chunk ? LW'(LAST_LANES) : LW'(P_EFF);

  a_done_single: assert property (@(posedge clk) disable iff (!in_Arst_n)
    (state_q == ST_DONE) |=> (state_q == ST_IDLE));
  a_adv_to_stream: assert property (@(posedge clk) disable iff (!in_Arst_n)
    ((state_q == ST_ADV) && !bus.in_abort) |=> (state_q == ST_STREAM));
  a_abort_idle: assert property (@(posedge clk) disable iff (!in_Arst_n)
    bus.in_abort |=> (state_q == ST_IDLE));
endmodule

// File: tb/tb_vector_load_sequencer.sv
// Scoreboard bench: each started pass queues its expected chunk sequence, which is
// popped and compared on every observed transfer; cycle-exact control timing is checked inline.
module tb_vector_load_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vector_load_sequencer_if #(.PARALLELISM(4), .WORD_LEN(10), .WORD_NUM(3)) ba ();
  vector_load_sequencer_if #(.PARALLELISM(4), .WORD_LEN(8),  .WORD_NUM(2)) bb ();

  vector_load_sequencer #(.PARALLELISM(4), .WORD_LEN(10), .WORD_NUM(3)) dut_a (
    .clk(clk), .in_Arst_n(rst_n), .bus(ba));
  vector_load_sequencer #(.PARALLELISM(4), .WORD_LEN(8), .WORD_NUM(2)) dut_b (
    .clk(clk), .in_Arst_n(rst_n), .bus(bb));

  typedef struct {int w; int c; int l; int f; int lc; int lw;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done_cyc;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected chunk sequence of one full pass, lanes from remaining bits of the word.
  task automatic push_pass(input bit to_b, input int p, input int wl, input int wn);
    int ch = (wl + p - 1) / p;
    for (int w = 0; w < wn; w++) begin
      for (int c = 0; c < ch; c++) begin
        exp_t e;
        e.w  = w;
        e.c  = c;
        e.l  = (c == ch - 1) ? (wl - c * p) : p;
        e.f  = (c == 0) ? 1 : 0;
        e.lc = (c == ch - 1) ? 1 : 0;
        e.lw = (w == wn - 1) ? 1 : 0;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
  endtask

  task automatic score(input bit is_b, input int w, input int c, input int l,
                       input int f, input int lc, input int lw);
    exp_t  e;
    string p    = is_b ? "b" : "a";
    int    pend = is_b ? qb.size() : qa.size();
    chk({p, "_sb_pending"}, int'(pend > 0), 1);
    if (pend > 0) begin
      if (is_b) e = qb.pop_front();
      else      e = qa.pop_front();
      chk({p, "_word_idx"},   w,  e.w);
      chk({p, "_chunk_idx"},  c,  e.c);
      chk({p, "_lanes"},      l,  e.l);
      chk({p, "_first"},      f,  e.f);
      chk({p, "_last_chunk"}, lc, e.lc);
      chk({p, "_last_word"},  lw, e.lw);
    end
  endtask

  // One clock cycle: inputs applied after the edge, outputs sampled at the falling edge.
  task automatic drive(input bit sa, input bit aa, input bit ra,
                       input bit sb = 1'b0, input bit ab = 1'b0, input bit rb = 1'b1);
    @(posedge clk);
    #1;
    ba.in_start = sa; ba.in_abort = aa; ba.in_ready = ra;
    bb.in_start = sb; bb.in_abort = ab; bb.in_ready = rb;
    @(negedge clk);
    cyc++;
    if (ba.out_valid && ba.in_ready)
      score(1'b0, int'(ba.out_word_idx), int'(ba.out_chunk_idx), int'(ba.out_lanes),
            int'(ba.out_first_chunk), int'(ba.out_last_chunk), int'(ba.out_last_word));
    if (bb.out_valid && bb.in_ready)
      score(1'b1, int'(bb.out_word_idx), int'(bb.out_chunk_idx), int'(bb.out_lanes),
            int'(bb.out_first_chunk), int'(bb.out_last_chunk), int'(bb.out_last_word));
  endtask

  task automatic chk_idle_a(input string p);
    chk({p, "_srst"},   int'(ba.out_ldr_Srst), 1);
    chk({p, "_en"},     int'(ba.out_ldr_en), 0);
    chk({p, "_nxt"},    int'(ba.out_ldr_next_word), 0);
    chk({p, "_valid"},  int'(ba.out_valid), 0);
    chk({p, "_busy"},   int'(ba.out_busy), 0);
    chk({p, "_done"},   int'(ba.out_done), 0);
    chk({p, "_first"},  int'(ba.out_first_chunk), 1);
    chk({p, "_lastc"},  int'(ba.out_last_chunk), 0);
    chk({p, "_lastw"},  int'(ba.out_last_word), 0);
    chk({p, "_lanes"},  int'(ba.out_lanes), 4);
    chk({p, "_word"},   int'(ba.out_word_idx), 0);
    chk({p, "_chunk"},  int'(ba.out_chunk_idx), 0);
  endtask

  task automatic wait_done_a(input string tag, input int exp_cyc);
    done_cyc = -1;
    while (done_cyc < 0 && cyc < exp_cyc + 20) begin
      drive(1'b0, 1'b0, 1'b1);
      if (ba.out_done) done_cyc = cyc;
    end
    chk(tag, done_cyc, exp_cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    bit adv, strm, stall;
    rst_n = 1'b0;
    ba.in_start = 1'b0; ba.in_abort = 1'b0; ba.in_ready = 1'b1;
    bb.in_start = 1'b0; bb.in_abort = 1'b0; bb.in_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_a("rst_a");
    chk("rst_b_srst",  int'(bb.out_ldr_Srst), 1);
    chk("rst_b_valid", int'(bb.out_valid), 0);
    chk("rst_b_lanes", int'(bb.out_lanes), 4);
    chk("rst_b_lastc", int'(bb.out_last_chunk), 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    chk_idle_a("idle_a");

    // Full-rate pass; a start pulse mid-pass at cycle 6 must be ignored
    push_pass(1'b0, 4, 10, 3);
    cyc = -1;
    drive(1'b1, 1'b0, 1'b1);
    chk("fr_c0_busy", int'(ba.out_busy), 0);
    for (int k = 1; k <= 14; k++) begin
      drive(k == 6, 1'b0, 1'b1);
      adv  = (k == 1 || k == 5 || k == 9);
      strm = (k >= 2 && k <= 4) || (k >= 6 && k <= 8) || (k >= 10 && k <= 12);
      chk("fr_next_word", int'(ba.out_ldr_next_word), int'(adv));
      chk("fr_valid",     int'(ba.out_valid),         int'(strm));
      chk("fr_en",        int'(ba.out_ldr_en),        int'(adv || strm));
      chk("fr_done",      int'(ba.out_done),          int'(k == 13));
      chk("fr_busy",      int'(ba.out_busy),          int'(k <= 13));
    end
    chk("fr_sb_drained", qa.size(), 0);

    // Backpressure on cycles 3-5
    push_pass(1'b0, 4, 10, 3);
    cyc = -1;
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      stall = (k >= 3 && k <= 5);
      drive(1'b0, 1'b0, !stall);
      if (stall) begin
        chk("bp_chunk", int'(ba.out_chunk_idx), 1);
        chk("bp_word",  int'(ba.out_word_idx), 0);
        chk("bp_en",    int'(ba.out_ldr_en), 0);
        chk("bp_valid", int'(ba.out_valid), 1);
        chk("bp_lanes", int'(ba.out_lanes), 4);
        chk("bp_first", int'(ba.out_first_chunk), 0);
      end
      chk("bp_done", int'(ba.out_done), int'(k == 16));
    end
    chk("bp_sb_drained", qa.size(), 0);

    // Abort at cycle 7, restart at cycle 9
    push_pass(1'b0, 4, 10, 3);
    cyc = -1;
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    chk("ab_valid", int'(ba.out_valid), 0);
    chk("ab_en",    int'(ba.out_ldr_en), 0);
    chk("ab_nxt",   int'(ba.out_ldr_next_word), 0);
    chk("ab_done7", int'(ba.out_done), 0);
    drive(1'b0, 1'b0, 1'b1);
    chk("ab_busy8",  int'(ba.out_busy), 0);
    chk("ab_word8",  int'(ba.out_word_idx), 0);
    chk("ab_chunk8", int'(ba.out_chunk_idx), 0);
    chk("ab_done8",  int'(ba.out_done), 0);
    chk("ab_sb_left", qa.size(), 5);
    qa.delete();
    push_pass(1'b0, 4, 10, 3);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ab_nxt10", int'(ba.out_ldr_next_word), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ab_valid11", int'(ba.out_valid), 1);
    chk("ab_chunk11", int'(ba.out_chunk_idx), 0);
    wait_done_a("ab_done_cycle", 22);
    drive(1'b0, 1'b0, 1'b1);
    chk("ab_sb_drained", qa.size(), 0);

    // Start together with abort in IDLE
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("sa_busy", int'(ba.out_busy), 0);
    chk("sa_srst", int'(ba.out_ldr_Srst), 1);
    chk("sa_nxt",  int'(ba.out_ldr_next_word), 0);

    // Exact multiple on the second instance
    push_pass(1'b1, 4, 8, 2);
    cyc = -1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      chk("em_valid", int'(bb.out_valid), int'(k == 2 || k == 3 || k == 5 || k == 6));
      chk("em_done",  int'(bb.out_done),  int'(k == 7));
      if (k == 3 || k == 6) chk("em_lastc", int'(bb.out_last_chunk), 1);
    end
    chk("em_sb_drained", qb.size(), 0);

    // Asynchronous reset mid-STREAM, then a clean restart
    push_pass(1'b0, 4, 10, 3);
    cyc = -1;
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) drive(1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_a("ar");
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_pass(1'b0, 4, 10, 3);
    cyc = -1;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ar_nxt1", int'(ba.out_ldr_next_word), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ar_valid2", int'(ba.out_valid), 1);
    chk("ar_word2",  int'(ba.out_word_idx), 0);
    chk("ar_chunk2", int'(ba.out_chunk_idx), 0);
    wait_done_a("ar_done_cycle", 13);
    chk("ar_sb_drained", qa.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
